bulk_in_arbiter: RTL and testbench
==================================

Name: bulk_in_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one bulk IN endpoint byte stream between up to 16 AXI-Stream sources.
- Sits in the axis_aclk domain, directly upstream of the bulk IN endpoint's AXIS input.
- Once a source is granted, it keeps the grant until its tlast beat.
- Can prepend a one-byte channel header to each frame so the host can demultiplex.

Parameters:
- NUM_SRC, 4, number of source ports; legal range 2..16.
- HEADER_EN, 1, 1 = insert a header byte before each frame; 0 = pass frames unmodified.
- HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
- axis_aclk  input  1  clock.
- reset_n  input  1  synchronous, active-low reset.
- chan_en_i  input  NUM_SRC  per-source enable mask; a disabled source is never granted.
- s_tvalid_i  input  NUM_SRC  per-source tvalid.
- s_tready_o  output  NUM_SRC  per-source tready.
- s_tlast_i  input  NUM_SRC  per-source tlast.
- s_tdata_i  input  8*NUM_SRC  per-source data; source k occupies bits [8k+7:8k].
- m_tvalid_o  output  1  tvalid to the endpoint.
- m_tready_i  input  1  tready from the endpoint.
- m_tlast_o  output  1  tlast to the endpoint.
- m_tdata_o  output  8  data to the endpoint.
- grant_o  output  NUM_SRC  one-hot current grant; all zero in IDLE.
- busy_o  output  1  high whenever state is not IDLE.
- frame_cnt_o  output  16  count of completed frames; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (synchronous, active-low):
  - state = IDLE, grant_o = 0, busy_o = 0, frame_cnt_o = 0.
  - Round-robin pointer last_q = NUM_SRC-1, so source 0 has first priority.
  - m_tvalid_o = 0, s_tready_o = 0.
  - Reset asserted mid-frame drops the frame immediately with no tlast emitted; upstream owns recovery.
- States: IDLE, HEAD, DATA.
- IDLE:
  - req = s_tvalid_i & chan_en_i.
  - If req != 0, select the first set bit searching last_q+1, last_q+2, ... modulo NUM_SRC.
  - Register the selection into grant_o. Next state is HEAD if HEADER_EN, else DATA.
  - All outputs stay 0 in IDLE, so arbitration costs one idle cycle per frame.
- HEAD:
  - m_tvalid_o = 1, m_tdata_o = {HDR_TAG, ch[3:0]}, m_tlast_o = 0, s_tready_o = 0.
  - Output is held stable until m_tready_i = 1; then go to DATA.
  - m_tvalid_o is never withdrawn once raised.
- DATA, combinational pass-through of granted source g:
  - m_tvalid_o = s_tvalid_i[g], m_tdata_o = s_tdata_i[g], m_tlast_o = s_tlast_i[g].
  - s_tready_o[g] = m_tready_i; all other s_tready_o bits = 0.
  - On a beat with m_tvalid_o & m_tready_i & m_tlast_o: last_q <= g, frame_cnt_o += 1, grant_o <= 0, state <= IDLE.
- Grant lock:
  - chan_en_i falling for the granted source mid-frame does not abort; the frame completes.
  - The enable mask is sampled only in IDLE.
- Simultaneous requests: a strict rotation guarantees each enabled, continuously requesting source one frame per NUM_SRC frames. No starvation.
- Source valid is allowed to drop mid-frame. The output simply stalls and the grant is held indefinitely; there is no timeout.
- A single-beat frame (tlast on the first data beat) is legal. It costs IDLE + HEAD + 1 beat = 3 cycles minimum with HEADER_EN=1.
- No registers on the DATA path. Latency in DATA is 0 cycles, s->m combinational; the endpoint's FIFO provides the timing break.
- Width rules:
  - ch is the grant index zero-extended to 4 bits.
  - The round-robin index arithmetic wraps modulo NUM_SRC (not a power of two in general; use a compare-and-reset, not bit truncation).

Decomposition:
- Package bulk_in_pkg: state encodings ST_IDLE = 2'd0, ST_HEAD = 2'd1, ST_DATA = 2'd2; default HDR_TAG; the MAX_SRC = 16 constant.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req[NUM_SRC], last index.
  - Outputs: one-hot grant, binary index, valid.
  - Reusable by the future OUT-side demux.
- The top level holds the FSM, the muxes and the counter.

Test Plan:
1. Reset, then source 1 sends 3 bytes 11,22,33 (tlast on 33), m_tready_i=1, HEADER_EN=1 -> output A1,11,22,33 with tlast only on 33; grant_o=0010 during the frame; frame_cnt_o=1; s_tready_o[1] high only in DATA.
2. All 4 sources continuously valid with 2-byte frames, chan_en_i=1111 -> header sequence A0,A1,A2,A3,A0; exactly one idle cycle between frames.
3. Source 2 frame in progress, source 0 raises valid -> source 0 gets no tready until source 2's tlast beat; source 0 is granted next.
4. m_tready_i held 0 for 5 cycles during HEAD -> m_tvalid_o=1 and m_tdata_o=A3 stable throughout; no source tready.
5. chan_en_i=1011, sources 2 and 3 valid -> only source 3 granted; then chan_en_i[3] cleared mid-frame -> frame still completes with tlast.
6. Reset pulsed on the 2nd data beat of a frame -> next cycle m_tvalid_o=0, grant_o=0, frame_cnt_o=0; source 0 has priority afterwards. Separately, 65536 single-byte frames -> frame_cnt_o wraps to 0.

Source files
------------

// File: rtl/bulk_in_pkg.sv
// Shared definitions for the bulk IN arbiter and its round-robin picker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bulk_in_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [3:0] DEF_HDR_TAG = 4'hA;
   localparam int         MAX_SRC     = 16;

endpackage

// File: rtl/bulk_in_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
// Ports: req (request mask), last (index granted most recently),
//        grant (one-hot pick), idx (binary pick), vld (some request present).
module rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int IW      = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [NUM_SRC-1:0] grant,
   output logic [IW-1:0]      idx,
   output logic               vld
);

   logic [IW-1:0] cand;

   // Walk last+1, last+2, ... ; the wrap is a compare-and-reset because
   // NUM_SRC need not be a power of two.
   always_comb begin
      grant = '0;
      idx   = '0;
      vld   = 1'b0;
      cand  = last;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cand == IW'(NUM_SRC - 1)) cand = '0;
         else                          cand = cand + 1'b1;
         if (!vld && req[cand]) begin
            vld         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bulk_in_arbiter.sv
// Frame-granular round-robin arbiter sharing one bulk IN byte stream among
// NUM_SRC AXI-Stream sources, with an optional {HDR_TAG, ch} header byte.
// Latency: one idle arbitration cycle per frame (+1 header beat); data path 0 cycles.
// Backpressure: m_tready_i passes straight to the granted source; header waits on it.
// Ports: chan_en_i/s_t*_i per-source enable and AXIS inputs, s_tready_o per source,
//        m_t* to the endpoint, grant_o one-hot grant, busy_o not-idle,
//        frame_cnt_o completed-frame count (wraps).
module bulk_in_arbiter
   import bulk_in_pkg::*;
#(
   parameter int         NUM_SRC   = 4,
   parameter bit         HEADER_EN = 1'b1,
   parameter logic [3:0] HDR_TAG   = DEF_HDR_TAG
) (
   input  logic                 axis_aclk,
   input  logic                 reset_n,
   input  logic [NUM_SRC-1:0]   chan_en_i,
   input  logic [NUM_SRC-1:0]   s_tvalid_i,
   output logic [NUM_SRC-1:0]   s_tready_o,
   input  logic [NUM_SRC-1:0]   s_tlast_i,
   input  logic [8*NUM_SRC-1:0] s_tdata_i,
   output logic                 m_tvalid_o,
   input  logic                 m_tready_i,
   output logic                 m_tlast_o,
   output logic [7:0]           m_tdata_o,
   output logic [NUM_SRC-1:0]   grant_o,
   output logic                 busy_o,
   output logic [15:0]          frame_cnt_o
);

   localparam int IW = $clog2(NUM_SRC);

   if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
      $error("bulk_in_arbiter: NUM_SRC out of range");
   end

   state_t               state;
   logic [NUM_SRC-1:0]   grant;
   logic [IW-1:0]        g;
   logic [IW-1:0]        last_q;
   logic [15:0]          frame_cnt;
   logic [NUM_SRC-1:0]   pick_grant;
   logic [IW-1:0]        pick_idx;
   logic                 pick_vld;
   logic [3:0]           ch;

   rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
      .req   (s_tvalid_i & chan_en_i),
      .last  (last_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .vld   (pick_vld)
   );

   assign ch = 4'(g);

   // The enable mask only matters here in IDLE: once granted, the frame runs to tlast.
   always_ff @(posedge axis_aclk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         grant     <= '0;
         g         <= '0;
         last_q    <= IW'(NUM_SRC - 1);
         frame_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant <= pick_grant;
                  g     <= pick_idx;
                  state <= HEADER_EN ? ST_HEAD : ST_DATA;
               end
            end
            ST_HEAD: begin
               if (m_tready_i) state <= ST_DATA;
            end
            ST_DATA: begin
               if (m_tvalid_o && m_tready_i && m_tlast_o) begin
                  last_q    <= g;
                  frame_cnt <= frame_cnt + 16'd1;
                  grant     <= '0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      m_tvalid_o = 1'b0;
      m_tlast_o  = 1'b0;
      m_tdata_o  = 8'h00;
      s_tready_o = '0;
      case (state)
         ST_HEAD: begin
            m_tvalid_o = 1'b1;
            m_tdata_o  = {HDR_TAG, ch};
         end
         ST_DATA: begin
            m_tvalid_o    = s_tvalid_i[g];
            m_tlast_o     = s_tlast_i[g];
            m_tdata_o     = s_tdata_i[8*g +: 8];
            s_tready_o[g] = m_tready_i;
         end
         default: ;
      endcase
   end

   assign grant_o     = grant;
   assign busy_o      = (state != ST_IDLE);
   assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_bulk_in_arbiter.sv
// Directed bench for bulk_in_arbiter (NUM_SRC=4, header on, tag A).
// Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after it.
module tb_bulk_in_arbiter;

   logic        axis_aclk = 1'b0;
   logic        reset_n;
   logic [3:0]  chan_en_i, s_tvalid_i, s_tready_o, s_tlast_i, grant_o;
   logic [31:0] s_tdata_i;
   logic        m_tvalid_o, m_tready_i, m_tlast_o, busy_o;
   logic [7:0]  m_tdata_o;
   logic [15:0] frame_cnt_o;

   int total = 0;
   int bad   = 0;

   always #5 axis_aclk = ~axis_aclk;

   bulk_in_arbiter #(.NUM_SRC(4), .HEADER_EN(1'b1), .HDR_TAG(4'hA)) dut (
      .axis_aclk   (axis_aclk),
      .reset_n     (reset_n),
      .chan_en_i   (chan_en_i),
      .s_tvalid_i  (s_tvalid_i),
      .s_tready_o  (s_tready_o),
      .s_tlast_i   (s_tlast_i),
      .s_tdata_i   (s_tdata_i),
      .m_tvalid_o  (m_tvalid_o),
      .m_tready_i  (m_tready_i),
      .m_tlast_o   (m_tlast_o),
      .m_tdata_o   (m_tdata_o),
      .grant_o     (grant_o),
      .busy_o      (busy_o),
      .frame_cnt_o (frame_cnt_o)
   );

   typedef struct {
      logic [3:0]  en, vld, last;
      logic [31:0] dat;
      logic        rdy;
      logic        e_mvld, e_mlast;
      logic [7:0]  e_mdat;
      logic [3:0]  e_srdy, e_grant;
      logic        e_busy;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic cyc();
      @(posedge axis_aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [34:0] outs();
      return {m_tvalid_o, m_tlast_o, m_tdata_o, s_tready_o, grant_o, busy_o, frame_cnt_o};
   endfunction

   task automatic add(input logic [3:0] en, input logic [3:0] vld, input logic [3:0] last,
                      input logic [31:0] dat, input logic rdy, input logic mv, input logic ml,
                      input logic [7:0] md, input logic [3:0] sr, input logic [3:0] gr,
                      input logic bz, input logic [15:0] cn);
      vecs.push_back('{en, vld, last, dat, rdy, mv, ml, md, sr, gr, bz, cn});
   endtask

   logic [3:0]  beat;
   logic [9:0]  exp10;
   int          src;

   initial begin
      // Single-frame, cross-request, and header-stall vectors.
      add(4'hF, 4'h2, 4'h0, 32'h0000_1100, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd0);
      add(4'hF, 4'h2, 4'h0, 32'h0000_1100, 1, 1, 0, 8'hA1, 4'h0, 4'h2, 1, 16'd0);
      add(4'hF, 4'h2, 4'h0, 32'h0000_1100, 1, 1, 0, 8'h11, 4'h2, 4'h2, 1, 16'd0);
      add(4'hF, 4'h2, 4'h0, 32'h0000_2200, 1, 1, 0, 8'h22, 4'h2, 4'h2, 1, 16'd0);
      add(4'hF, 4'h2, 4'h2, 32'h0000_3300, 1, 1, 1, 8'h33, 4'h2, 4'h2, 1, 16'd0);
      add(4'hF, 4'h0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd1);
      add(4'hF, 4'h4, 4'h0, 32'h0055_0000, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd1);
      add(4'hF, 4'h5, 4'h0, 32'h0055_0066, 1, 1, 0, 8'hA2, 4'h0, 4'h4, 1, 16'd1);
      add(4'hF, 4'h5, 4'h0, 32'h0055_0066, 1, 1, 0, 8'h55, 4'h4, 4'h4, 1, 16'd1);
      add(4'hF, 4'h5, 4'h4, 32'h0057_0066, 1, 1, 1, 8'h57, 4'h4, 4'h4, 1, 16'd1);
      add(4'hF, 4'h1, 4'h1, 32'h0000_0066, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd2);
      add(4'hF, 4'h1, 4'h1, 32'h0000_0066, 1, 1, 0, 8'hA0, 4'h0, 4'h1, 1, 16'd2);
      add(4'hF, 4'h1, 4'h1, 32'h0000_0066, 1, 1, 1, 8'h66, 4'h1, 4'h1, 1, 16'd2);
      add(4'hF, 4'h0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd3);
      add(4'hF, 4'h8, 4'h8, 32'h7700_0000, 0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd3);
      for (int i = 0; i < 5; i++)
         add(4'hF, 4'h8, 4'h8, 32'h7700_0000, 0, 1, 0, 8'hA3, 4'h0, 4'h8, 1, 16'd3);
      add(4'hF, 4'h8, 4'h8, 32'h7700_0000, 1, 1, 0, 8'hA3, 4'h0, 4'h8, 1, 16'd3);
      add(4'hF, 4'h8, 4'h8, 32'h7700_0000, 1, 1, 1, 8'h77, 4'h8, 4'h8, 1, 16'd3);
      add(4'hF, 4'h0, 4'h0, 32'h0000_0000, 1, 0, 0, 8'h00, 4'h0, 4'h0, 0, 16'd4);

      reset_n = 1'b0; chan_en_i = '0; s_tvalid_i = '0; s_tlast_i = '0;
      s_tdata_i = '0; m_tready_i = 1'b0;
      cyc(); cyc();
      #3;
      chk("reset_state", 64'(outs()), 64'(35'h0));

      foreach (vecs[i]) begin
         cyc();
         reset_n    = 1'b1;
         chan_en_i  = vecs[i].en;
         s_tvalid_i = vecs[i].vld;
         s_tlast_i  = vecs[i].last;
         s_tdata_i  = vecs[i].dat;
         m_tready_i = vecs[i].rdy;
         #3;
         chk($sformatf("vec%0d", i), 64'(outs()),
             64'({vecs[i].e_mvld, vecs[i].e_mlast, vecs[i].e_mdat, vecs[i].e_srdy,
                  vecs[i].e_grant, vecs[i].e_busy, vecs[i].e_cnt}));
      end

      // All four sources always valid, 2-byte frames: rotation from source 0.
      beat = '0;
      for (int c = 0; c < 20; c++) begin
         cyc();
         s_tvalid_i = 4'hF;
         chan_en_i  = 4'hF;
         m_tready_i = 1'b1;
         for (int k = 0; k < 4; k++) begin
            s_tlast_i[k]       = beat[k];
            s_tdata_i[8*k +: 8] = {4'(k), 3'b000, beat[k]};
         end
         #3;
         src = (c / 4) % 4;
         case (c % 4)
            0:       exp10 = 10'h000;
            1:       exp10 = {2'b10, 4'hA, 4'(src)};
            2:       exp10 = {2'b10, 4'(src), 4'h0};
            default: exp10 = {2'b11, 4'(src), 4'h1};
         endcase
         chk($sformatf("rotate%0d", c), 64'({m_tvalid_o, m_tlast_o, m_tdata_o}), 64'(exp10));
         for (int k = 0; k < 4; k++)
            if (s_tready_o[k]) beat[k] = ~beat[k];
      end
      cyc();
      s_tvalid_i = '0; s_tlast_i = '0; s_tdata_i = '0;
      #3;
      chk("rotate_cnt", 64'(frame_cnt_o), 64'd9);

      // Masked channel skipped; enable drop mid-frame does not abort.
      cyc();
      chan_en_i = 4'b1011; s_tvalid_i = 4'b1100; s_tdata_i = 32'h3020_0000;
      cyc();
      #3;
      chk("mask_grant", 64'({grant_o, m_tdata_o}), 64'({4'b1000, 8'hA3}));
      cyc();
      chan_en_i = 4'b0011;
      #3;
      chk("mask_beat1", 64'({s_tready_o, m_tvalid_o, m_tdata_o}), 64'({4'b1000, 1'b1, 8'h30}));
      cyc();
      s_tlast_i = 4'b1000; s_tdata_i = 32'h3120_0000;
      #3;
      chk("mask_last", 64'({m_tvalid_o, m_tlast_o, m_tdata_o}), 64'({2'b11, 8'h31}));
      cyc();
      s_tlast_i = '0;
      #3;
      chk("mask_idle", 64'({grant_o, busy_o, frame_cnt_o}), 64'({4'h0, 1'b0, 16'd10}));
      cyc();
      #3;
      chk("mask_src2_blocked", 64'({grant_o, busy_o}), 64'({4'h0, 1'b0}));

      // Complete a source-0 frame, start source 1, reset on its second data beat.
      cyc();
      chan_en_i = 4'hF; s_tvalid_i = 4'b0001; s_tlast_i = 4'b0001; s_tdata_i = 32'h0000_000E;
      cyc(); cyc(); cyc();
      s_tvalid_i = 4'b0010; s_tlast_i = '0; s_tdata_i = 32'h0000_4000;
      #3;
      chk("pre_rst_cnt", 64'(frame_cnt_o), 64'd11);
      cyc(); cyc();
      #3;
      chk("rst_beat1", 64'({s_tready_o, m_tdata_o}), 64'({4'b0010, 8'h40}));
      cyc();
      s_tdata_i = 32'h0000_4100; reset_n = 1'b0;
      cyc();
      reset_n = 1'b1; s_tvalid_i = 4'b0011; s_tdata_i = 32'h0000_4150;
      #3;
      chk("rst_drop", 64'(outs()), 64'(35'h0));
      cyc();
      #3;
      chk("rst_prio", 64'(grant_o), 64'(4'b0001));
      cyc();
      reset_n = 1'b0; s_tvalid_i = '0;
      cyc();
      reset_n = 1'b1;

      // Counter wrap: preload near the top, then two single-byte frames.
      cyc();
      force dut.frame_cnt = 16'hFFFE;
      cyc();
      release dut.frame_cnt;
      s_tvalid_i = 4'b0001; s_tlast_i = 4'b0001; s_tdata_i = 32'h0000_0001;
      cyc(); cyc(); cyc();
      #3;
      chk("cnt_ffff", 64'(frame_cnt_o), 64'hFFFF);
      cyc(); cyc(); cyc();
      s_tvalid_i = '0;
      #3;
      chk("cnt_wrap", 64'(frame_cnt_o), 64'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
